audio_stream_checker: RTL and testbench

AUDIO_STREAM_CHECKER -- requirements
Module: audio_stream_checker

---
 rtl/audio_stream_checker.sv | 211 +++++++++++++++++++++
 tb/tb_audio_stream_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_checker.sv
// audio_stream_checker
// Pops matching frames from NUM_CH DUT and reference FWFT FIFOs in lockstep,
// compares each channel within an absolute tolerance and keeps run statistics.
module audio_stream_checker #(
   parameter int          NUM_CH = 2,
   parameter int          DATA_W = 32,
   parameter int          CNT_W  = 32,
   parameter int unsigned TOL    = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [CNT_W-1:0]         sample_count,
   input  logic [NUM_CH-1:0]        dut_empty,
   input  logic [NUM_CH*DATA_W-1:0] dut_data,
   output logic [NUM_CH-1:0]        dut_rd_en,
   input  logic [NUM_CH-1:0]        ref_empty,
   input  logic [NUM_CH*DATA_W-1:0] ref_data,
   output logic [NUM_CH-1:0]        ref_rd_en,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         sample_index,
   output logic [CNT_W-1:0]         error_count,
   output logic                     mismatch,
   output logic                     first_err_valid,
   output logic [CNT_W-1:0]         first_err_index,
   output logic [2:0]               first_err_chan
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [DATA_W:0]  TOL_X   = (DATA_W+1)'(TOL);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Absolute difference of two signed samples, widened by one bit so it never wraps.
   function automatic logic chan_mismatch(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic [DATA_W:0] diff;
      logic [DATA_W:0] mag;
      diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
      if (diff[DATA_W]) begin
         mag = (~diff) + {{DATA_W{1'b0}}, 1'b1};
      end else begin
         mag = diff;
      end
      return (mag > TOL_X);
   endfunction

   // Number of set bits in the per-channel mismatch vector.
   function automatic logic [3:0] pop_count(input logic [NUM_CH-1:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (v[k]) begin
            n = n + 4'd1;
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // Index of the lowest set bit (scan downwards so the lowest wins).
   function automatic logic [2:0] lowest_chan(input logic [NUM_CH-1:0] v);
      logic [2:0] c;
      c = 3'd0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (v[k]) begin
            c = 3'(k);
         end else begin
            c = c;
         end
      end
      return c;
   endfunction

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  sample_index_r;
   logic [CNT_W-1:0]  error_count_r;
   logic              mismatch_r;
   logic              first_err_valid_r;
   logic [CNT_W-1:0]  first_err_index_r;
   logic [2:0]        first_err_chan_r;
   logic              busy_r;
   logic              done_r;

   logic              fire_s;
   logic              accept_s;
   logic              last_s;
   logic [NUM_CH-1:0] chan_mm_s;
   logic              any_mm_s;
   logic [CNT_W:0]    err_sum_s;
   logic [CNT_W-1:0]  err_next_s;

   assign fire_s   = (state_r == RUN) && !(|dut_empty) && !(|ref_empty);
   assign accept_s = start && (state_r != RUN);
   assign last_s   = ((sample_index_r + CNT_ONE) == count_r);

   assign dut_rd_en = {NUM_CH{fire_s}};
   assign ref_rd_en = {NUM_CH{fire_s}};

   // Per-channel tolerance compare of the frame currently at the FIFO heads.
   always_comb begin
      chan_mm_s = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         chan_mm_s[k] = chan_mismatch(dut_data[k*DATA_W +: DATA_W], ref_data[k*DATA_W +: DATA_W]);
      end
   end

   assign any_mm_s = |chan_mm_s;

   // Saturating accumulation of mismatching channels.
   always_comb begin
      err_sum_s = {1'b0, error_count_r} + (CNT_W+1)'(pop_count(chan_mm_s));
      if (err_sum_s[CNT_W]) begin
         err_next_s = CNT_MAX;
      end else begin
         err_next_s = err_sum_s[CNT_W-1:0];
      end
   end

   // Next-state logic: a start outside RUN (re)launches, the final frame ends the run.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               if (sample_count == {CNT_W{1'b0}}) begin
                  state_s = DONE;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = state_r;
            end
         end
         RUN: begin
            if (fire_s && last_s) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register with status flags registered alongside it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == RUN);
         done_r  <= (state_s == DONE);
      end
   end

   // Run counters and first-error capture: cleared on launch, updated on each fired frame.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_r           <= {CNT_W{1'b0}};
         sample_index_r    <= {CNT_W{1'b0}};
         error_count_r     <= {CNT_W{1'b0}};
         mismatch_r        <= 1'b0;
         first_err_valid_r <= 1'b0;
         first_err_index_r <= {CNT_W{1'b0}};
         first_err_chan_r  <= 3'd0;
      end else if (accept_s) begin
         count_r           <= sample_count;
         sample_index_r    <= {CNT_W{1'b0}};
         error_count_r     <= {CNT_W{1'b0}};
         mismatch_r        <= 1'b0;
         first_err_valid_r <= 1'b0;
         first_err_index_r <= {CNT_W{1'b0}};
         first_err_chan_r  <= 3'd0;
      end else if (fire_s) begin
         sample_index_r <= sample_index_r + CNT_ONE;
         error_count_r  <= err_next_s;
         mismatch_r     <= any_mm_s;
         if (!first_err_valid_r && any_mm_s) begin
            first_err_valid_r <= 1'b1;
            first_err_index_r <= sample_index_r;
            first_err_chan_r  <= lowest_chan(chan_mm_s);
         end else begin
            first_err_valid_r <= first_err_valid_r;
         end
      end else begin
         mismatch_r <= 1'b0;
      end
   end

   assign busy            = busy_r;
   assign done            = done_r;
   assign sample_index    = sample_index_r;
   assign error_count     = error_count_r;
   assign mismatch        = mismatch_r;
   assign first_err_valid = first_err_valid_r;
   assign first_err_index = first_err_index_r;
   assign first_err_chan  = first_err_chan_r;

endmodule

// File: tb/tb_audio_stream_checker.sv
// Table-driven bench for audio_stream_checker: a TOL=0 instance driven by a vector
// table, plus hand-written tolerance and mid-run reset sequences; a TOL=2 instance
// shares the stimulus.
module tb_audio_stream_checker;

   logic               clock;
   logic               reset;
   logic               start;
   logic [31:0]        sample_count;
   logic [1:0]         dut_empty;
   logic [1:0]         ref_empty;
   logic [63:0]        dut_data;
   logic [63:0]        ref_data;

   logic [1:0]  a_dut_rd, a_ref_rd, b_dut_rd, b_ref_rd;
   logic        a_busy, a_done, a_mm, a_fev, b_busy, b_done, b_mm, b_fev;
   logic [31:0] a_idx, a_err, a_fei, b_idx, b_err, b_fei;
   logic [2:0]  a_fec, b_fec;

   int total;
   int bad;

   audio_stream_checker #(.NUM_CH(2), .DATA_W(32), .CNT_W(32), .TOL(0)) u_a (
      .clock(clock), .reset(reset), .start(start), .sample_count(sample_count),
      .dut_empty(dut_empty), .dut_data(dut_data), .dut_rd_en(a_dut_rd),
      .ref_empty(ref_empty), .ref_data(ref_data), .ref_rd_en(a_ref_rd),
      .busy(a_busy), .done(a_done), .sample_index(a_idx), .error_count(a_err),
      .mismatch(a_mm), .first_err_valid(a_fev), .first_err_index(a_fei),
      .first_err_chan(a_fec));

   audio_stream_checker #(.NUM_CH(2), .DATA_W(32), .CNT_W(32), .TOL(2)) u_b (
      .clock(clock), .reset(reset), .start(start), .sample_count(sample_count),
      .dut_empty(dut_empty), .dut_data(dut_data), .dut_rd_en(b_dut_rd),
      .ref_empty(ref_empty), .ref_data(ref_data), .ref_rd_en(b_ref_rd),
      .busy(b_busy), .done(b_done), .sample_index(b_idx), .error_count(b_err),
      .mismatch(b_mm), .first_err_valid(b_fev), .first_err_index(b_fei),
      .first_err_chan(b_fec));

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        st;
      logic [31:0] cnt;
      logic [1:0]  de;
      logic [1:0]  re;
      int          dl, dr, rl, rr;
      logic        rd;
      logic        busy, done;
      logic [31:0] idx, err;
      logic        mm, fev;
      logic [31:0] fei;
      logic [2:0]  fec;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t mk(input int st, input int cnt, input int de, input int re,
                               input int dl, input int dr, input int rl, input int rr,
                               input int rd, input int busy, input int done, input int idx,
                               input int err, input int mm, input int fev, input int fei,
                               input int fec);
      vec_t v;
      v.st = st[0]; v.cnt = cnt; v.de = de[1:0]; v.re = re[1:0];
      v.dl = dl; v.dr = dr; v.rl = rl; v.rr = rr;
      v.rd = rd[0]; v.busy = busy[0]; v.done = done[0]; v.idx = idx; v.err = err;
      v.mm = mm[0]; v.fev = fev[0]; v.fei = fei; v.fec = fec[2:0];
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic [31:0] cnt, input logic [1:0] de,
                        input logic [1:0] re, input int dl, input int dr, input int rl,
                        input int rr);
      start = st; sample_count = cnt; dut_empty = de; ref_empty = re;
      dut_data = {dr[31:0], dl[31:0]};
      ref_data = {rr[31:0], rl[31:0]};
   endtask

   task automatic next_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic check_a_all_zero(input string tag);
      check({tag, ".dut_rd"}, {62'd0, a_dut_rd}, 64'd0);
      check({tag, ".ref_rd"}, {62'd0, a_ref_rd}, 64'd0);
      check({tag, ".busy"}, {63'd0, a_busy}, 64'd0);
      check({tag, ".done"}, {63'd0, a_done}, 64'd0);
      check({tag, ".idx"}, {32'd0, a_idx}, 64'd0);
      check({tag, ".err"}, {32'd0, a_err}, 64'd0);
      check({tag, ".mm"}, {63'd0, a_mm}, 64'd0);
      check({tag, ".fev"}, {63'd0, a_fev}, 64'd0);
      check({tag, ".fei"}, {32'd0, a_fei}, 64'd0);
      check({tag, ".fec"}, {61'd0, a_fec}, 64'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      drive(1'b0, 32'd0, 2'b11, 2'b11, 0, 0, 0, 0);

      //  st cnt de re   dl    dr   rl   rr | rd bsy dn idx err mm fev fei fec
      // Identical streams, 4 frames, then DONE holds with no pops.
      tbl[0]  = mk(1, 4, 0, 0,    1,   1,   1,   1,  0, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0,   10,  20,  10,  20,  1, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0,   11,  21,  11,  21,  1, 1, 0, 2, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0,   12,  22,  12,  22,  1, 1, 0, 3, 0, 0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0,   13,  23,  13,  23,  1, 0, 1, 4, 0, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0,   14,  24,  14,  24,  0, 0, 1, 4, 0, 0, 0, 0, 0);
      // Restart from DONE; start in RUN ignored; frame 2 mismatches on L.
      tbl[6]  = mk(1, 4, 0, 0,    1,   1,   1,   1,  0, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0,    1,   1,   1,   1,  1, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[8]  = mk(1, 9, 0, 0,    2,   2,   2,   2,  1, 1, 0, 2, 0, 0, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 0,    5,  -3,   7,  -3,  1, 1, 0, 3, 1, 1, 1, 2, 0);
      tbl[10] = mk(0, 0, 0, 0,    4,   4,   4,   4,  1, 0, 1, 4, 1, 0, 1, 2, 0);
      // ref_empty[1] stalls for 5 cycles; mismatching heads must not be counted.
      tbl[11] = mk(1, 3, 0, 0,    0,   0,   0,   0,  0, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[12] = mk(0, 0, 0, 0,    6,   6,   6,   6,  1, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[13] = mk(0, 0, 0, 2,    9,   9,   0,   0,  0, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 0, 2,    9,   9,   0,   0,  0, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[15] = mk(0, 0, 0, 2,    9,   9,   0,   0,  0, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[16] = mk(0, 0, 0, 2,    9,   9,   0,   0,  0, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[17] = mk(0, 0, 0, 2,    9,   9,   0,   0,  0, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[18] = mk(0, 0, 0, 0,    7,   7,   7,   7,  1, 1, 0, 2, 0, 0, 0, 0, 0);
      tbl[19] = mk(0, 0, 0, 0,    8,   8,   8,   0,  1, 0, 1, 3, 1, 1, 1, 2, 1);
      // Zero-length run, then a normal 3-frame run with a dut_empty stall.
      tbl[20] = mk(1, 0, 0, 0,    1,   1,   1,   1,  0, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[21] = mk(0, 0, 0, 0,    1,   1,   1,   1,  0, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[22] = mk(1, 3, 0, 0,    1,   1,   1,   1,  0, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[23] = mk(0, 0, 0, 0,    1,   1,   1,   1,  1, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[24] = mk(0, 0, 1, 0,    1,   1,   1,   1,  0, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[25] = mk(0, 0, 0, 0,    1,   1,   1,   1,  1, 1, 0, 2, 0, 0, 0, 0, 0);
      tbl[26] = mk(0, 0, 0, 0, -100, 100,-100, 100,  1, 0, 1, 3, 0, 0, 0, 0, 0);

      // Reset state.
      #12;
      check_a_all_zero("reset");
      reset = 1'b1;
      next_edge();

      // Table: rd_en checked combinationally mid-cycle, registers after the edge.
      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].st, tbl[i].cnt, tbl[i].de, tbl[i].re,
               tbl[i].dl, tbl[i].dr, tbl[i].rl, tbl[i].rr);
         @(negedge clock);
         check($sformatf("v%0d.dut_rd", i), {62'd0, a_dut_rd}, {62'd0, {2{tbl[i].rd}}});
         check($sformatf("v%0d.ref_rd", i), {62'd0, a_ref_rd}, {62'd0, {2{tbl[i].rd}}});
         next_edge();
         check($sformatf("v%0d.busy", i), {63'd0, a_busy}, {63'd0, tbl[i].busy});
         check($sformatf("v%0d.done", i), {63'd0, a_done}, {63'd0, tbl[i].done});
         check($sformatf("v%0d.idx", i), {32'd0, a_idx}, {32'd0, tbl[i].idx});
         check($sformatf("v%0d.err", i), {32'd0, a_err}, {32'd0, tbl[i].err});
         check($sformatf("v%0d.mm", i), {63'd0, a_mm}, {63'd0, tbl[i].mm});
         check($sformatf("v%0d.fev", i), {63'd0, a_fev}, {63'd0, tbl[i].fev});
         check($sformatf("v%0d.fei", i), {32'd0, a_fei}, {32'd0, tbl[i].fei});
         check($sformatf("v%0d.fec", i), {61'd0, a_fec}, {61'd0, tbl[i].fec});
      end

      // Tolerance: diffs +2 (L, within TOL=2) and -3 (R, beyond) in one frame.
      drive(1'b1, 32'd1, 2'b00, 2'b00, 0, 0, 0, 0);
      next_edge();
      drive(1'b0, 32'd0, 2'b00, 2'b00, 2, 0, 0, 3);
      next_edge();
      check("tol2.err", {32'd0, b_err}, 64'd1);
      check("tol2.fec", {61'd0, b_fec}, 64'd1);
      check("tol2.fev", {63'd0, b_fev}, 64'd1);
      check("tol2.fei", {32'd0, b_fei}, 64'd0);
      check("tol2.done", {63'd0, b_done}, 64'd1);
      check("tol0.err", {32'd0, a_err}, 64'd2);
      check("tol0.fec", {61'd0, a_fec}, 64'd0);

      // Mid-run reset after 2 frames, with a third frame being presented.
      drive(1'b1, 32'd5, 2'b00, 2'b00, 3, 3, 3, 3);
      next_edge();
      drive(1'b0, 32'd0, 2'b00, 2'b00, 3, 3, 3, 3);
      next_edge();
      next_edge();
      check("rst.pre_idx", {32'd0, a_idx}, 64'd2);
      #2;
      check("rst.pre_rd", {62'd0, a_dut_rd}, 64'd3);
      reset = 1'b0;
      #1;
      check_a_all_zero("rst.async");
      check("rst.b_busy", {63'd0, b_busy}, 64'd0);
      next_edge();
      check("rst.held_idx", {32'd0, a_idx}, 64'd0);
      reset = 1'b1;
      @(negedge clock);
      check("rst.idle_rd", {62'd0, a_dut_rd}, 64'd0);
      next_edge();
      check("rst.idle_busy", {63'd0, a_busy}, 64'd0);
      drive(1'b1, 32'd1, 2'b00, 2'b00, 3, 3, 3, 3);
      next_edge();
      check("rst.run_busy", {63'd0, a_busy}, 64'd1);
      drive(1'b0, 32'd0, 2'b00, 2'b00, 3, 3, 3, 3);
      next_edge();
      check("rst.final_idx", {32'd0, a_idx}, 64'd1);
      check("rst.final_done", {63'd0, a_done}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
